// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front of the pipeline. The unit drives the instruction-memory address from
// the program counter and captures the word that memory returns in the same
// cycle. Each {instruction, pc} pair goes into a small prefetch FIFO, so a
// decode stall never loses a fetch. Decode drains the FIFO over a valid/ready
// handshake. A redirect from execute flushes the FIFO and reloads the PC.
//
// Parameters
//   RESET_PC    PC loaded on reset (word aligned)
//   FIFO_DEPTH  prefetch entries (power of 2, >= 2)
//
// Ports
//   clk               rising-edge clock
//   reset_n           asynchronous active-low reset
//   fetch_en          1 = fetch allowed, 0 = hold PC and enqueue nothing
//   imem_address      byte address to instruction memory (equals PC)
//   imem_instruction  word returned combinationally for imem_address
//   redirect          taken branch / flush request from execute
//   redirect_target   new PC, low two bits ignored
//   out_valid         FIFO head valid
//   out_ready         decode accepts the head this cycle
//   out_instr         instruction at the FIFO head
//   out_pc            PC of out_instr
//   out_pc_plus8      out_pc + 8 (ARM-style PC read value)
//   perf_fetched      instructions enqueued
//   perf_flushed      FIFO entries discarded by redirects
//
// Build option
//   IFU_PERF_CNT_EN   when defined, builds the two performance counters.
//                     Otherwise perf_fetched and perf_flushed read zero.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus8,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      instr_q [FIFO_DEPTH];
    logic [31:0]      entry_pc_q [FIFO_DEPTH];

    logic fifo_full;
    logic deq;
    logic enq;
    logic [1:0] unused_target_lsbs;

    // The low target bits are discarded because instructions are word aligned.
    assign unused_target_lsbs = redirect_target[1:0];

    assign imem_address = pc_q;
    assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign out_valid    = (count_q != '0);
    assign deq          = out_valid & out_ready;
    // Enqueueing while full is allowed when the head leaves in the same cycle.
    assign enq          = fetch_en & ~redirect & (~fifo_full | deq);

    // Next-state logic. A redirect overrides everything: the pointers and the
    // count are cleared, and any word fetched or dequeued this cycle is ignored.
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            pc_d    = {redirect_target[31:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                pc_d   = pc_q + 32'd4;
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // FIFO storage. The storage is cleared on reset so the outputs read as
    // zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_q[i]    <= '0;
                entry_pc_q[i] <= '0;
            end
        end else if (enq) begin
            instr_q[tail_q]    <= imem_instruction;
            entry_pc_q[tail_q] <= pc_q;
        end
    end

    // Gating with out_valid gives zero outputs when the FIFO is empty.
    // This hides stale entries that remain after a flush.
    assign out_instr    = out_valid ? instr_q[head_q]    : 32'h0;
    assign out_pc       = out_valid ? entry_pc_q[head_q] : 32'h0;
    assign out_pc_plus8 = out_valid ? (entry_pc_q[head_q] + 32'd8) : 32'h0;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] flushed_q;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (enq) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (redirect) begin
                flushed_q <= flushed_q + 32'(count_q);
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`else
    assign perf_fetched = 32'h0;
    assign perf_flushed = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit. It runs directed scenarios and then a
// randomized phase. Both are checked against a queue-based reference model of
// the fetch unit. A second instance, with RESET_PC near the top of memory,
// exercises PC wrap-around.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetN;
    logic        fetchEn;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic        outReady;
    logic [31:0] imemAddress;
    logic [31:0] imemInstr;
    logic        outValid;
    logic [31:0] outInstr;
    logic [31:0] outPc;
    logic [31:0] outPcPlus8;
    logic [31:0] perfFetched;
    logic [31:0] perfFlushed;

    logic        wResetN;
    logic        wFetchEn;
    logic        wRedirect;
    logic [31:0] wTarget;
    logic        wReady;
    logic [31:0] wImemAddress;
    logic [31:0] wImemInstr;
    logic        wValid;
    logic [31:0] wInstr;
    logic [31:0] wPc;
    logic [31:0] wPcPlus8;
    logic [31:0] wPerfFetched;
    logic [31:0] wPerfFlushed;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mPc;
    logic [31:0] mFetched;
    logic [31:0] mFlushed;

    always #5 clk = ~clk;

    // The instruction memory holds the opening words of the Fibonacci program.
    // Every other address returns a distinct pattern.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hEF20_000C;
            32'h0000_0004: return 32'hEF20_1000;
            32'h0000_0008: return 32'hEF20_2001;
            32'h0000_0014: return 32'hE801_3002;
            default:       return {a[15:0] ^ 16'h5A3C, a[17:2] ^ 16'h1234};
        endcase
    endfunction

    assign imemInstr  = memWord(imemAddress);
    assign wImemInstr = memWord(wImemAddress);

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(resetN), .fetch_en(fetchEn),
        .imem_address(imemAddress), .imem_instruction(imemInstr),
        .redirect(redirect), .redirect_target(redirectTarget),
        .out_valid(outValid), .out_ready(outReady), .out_instr(outInstr),
        .out_pc(outPc), .out_pc_plus8(outPcPlus8),
        .perf_fetched(perfFetched), .perf_flushed(perfFlushed)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dutWrap (
        .clk(clk), .reset_n(wResetN), .fetch_en(wFetchEn),
        .imem_address(wImemAddress), .imem_instruction(wImemInstr),
        .redirect(wRedirect), .redirect_target(wTarget),
        .out_valid(wValid), .out_ready(wReady), .out_instr(wInstr),
        .out_pc(wPc), .out_pc_plus8(wPcPlus8),
        .perf_fetched(wPerfFetched), .perf_flushed(wPerfFlushed)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mPc      = 32'h0;
        mFetched = 32'h0;
        mFlushed = 32'h0;
    endtask

    // Reference behaviour for one clock edge, based on the current inputs.
    task automatic modelStep();
        bit doDeq;
        bit doEnq;
        doDeq = (mq.size() != 0) && outReady;
        if (redirect) begin
            mFlushed = mFlushed + 32'(mq.size());
            mq.delete();
            mPc = {redirectTarget[31:2], 2'b00};
        end else begin
            doEnq = fetchEn && ((mq.size() < DEPTH) || doDeq);
            if (doDeq) void'(mq.pop_front());
            if (doEnq) begin
                mq.push_back('{memWord(mPc), mPc});
                mPc      = mPc + 32'd4;
                mFetched = mFetched + 32'd1;
            end
        end
    endtask

    task automatic checkModel();
        checkOutput("valid", {31'b0, outValid}, {31'b0, mq.size() != 0});
        checkOutput("imem_address", imemAddress, mPc);
        if (mq.size() != 0) begin
            checkOutput("out_pc", outPc, mq[0].pc);
            checkOutput("out_instr", outInstr, mq[0].instr);
            checkOutput("out_pc_plus8", outPcPlus8, mq[0].pc + 32'd8);
        end
`ifdef IFU_PERF_CNT_EN
        checkOutput("perf_fetched", perfFetched, mFetched);
        checkOutput("perf_flushed", perfFlushed, mFlushed);
`else
        checkOutput("perf_fetched", perfFetched, 32'h0);
        checkOutput("perf_flushed", perfFlushed, 32'h0);
`endif
    endtask

    // One cycle. Inputs change on the falling edge, and the outputs are
    // sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic fe, input logic rdy, input logic rd, input logic [31:0] tgt);
        @(negedge clk);
        fetchEn        = fe;
        outReady       = rdy;
        redirect       = rd;
        redirectTarget = tgt;
        modelStep();
        @(posedge clk);
        #1;
        checkModel();
    endtask

    task automatic doReset();
        @(negedge clk);
        fetchEn  = 1'b0;
        outReady = 1'b0;
        redirect = 1'b0;
        resetN   = 1'b0;
        #1;
        checkOutput("reset_async_valid", {31'b0, outValid}, 32'h0);
        checkOutput("reset_async_pc", imemAddress, 32'h0);
        modelReset();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0; fetchEn = 1'b0; redirect = 1'b0; redirectTarget = '0; outReady = 1'b0;
        wResetN = 1'b0; wFetchEn = 1'b0; wRedirect = 1'b0; wTarget = '0; wReady = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", {31'b0, outValid}, 32'h0);
        checkOutput("rst_instr", outInstr, 32'h0);
        checkOutput("rst_pc", outPc, 32'h0);
        checkOutput("rst_pc_plus8", outPcPlus8, 32'h0);
        checkOutput("rst_imem_address", imemAddress, 32'h0);
        checkOutput("rst_perf_fetched", perfFetched, 32'h0);
        checkOutput("rst_perf_flushed", perfFlushed, 32'h0);
        @(negedge clk);
        resetN = 1'b1;

        // Streaming
        applyStimulus(1, 1, 0, 0);
        checkOutput("s1_pc", outPc, 32'h0);
        checkOutput("s1_instr", outInstr, 32'hEF20_000C);
        checkOutput("s1_pc8", outPcPlus8, 32'h8);
        applyStimulus(1, 1, 0, 0);
        checkOutput("s2_pc", outPc, 32'h4);
        checkOutput("s2_instr", outInstr, 32'hEF20_1000);
        checkOutput("s2_pc8", outPcPlus8, 32'hC);
        applyStimulus(1, 1, 0, 0);
        checkOutput("s3_pc", outPc, 32'h8);
        checkOutput("s3_instr", outInstr, 32'hEF20_2001);
        checkOutput("s3_pc8", outPcPlus8, 32'h10);

        // Stall
        doReset();
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0);
            checkOutput("stall_imem", imemAddress, 32'h8);
            checkOutput("stall_pc", outPc, 32'h0);
        end
        applyStimulus(1, 1, 0, 0);
        checkOutput("release_pc0", outPc, 32'h4);
        applyStimulus(1, 1, 0, 0);
        checkOutput("release_pc1", outPc, 32'h8);

        // Redirect with a full FIFO
        applyStimulus(1, 1, 1, 32'h16);
        checkOutput("redir_valid", {31'b0, outValid}, 32'h0);
        checkOutput("redir_imem", imemAddress, 32'h14);
        applyStimulus(1, 1, 0, 0);
        checkOutput("redir_pc", outPc, 32'h14);
        checkOutput("redir_instr", outInstr, 32'hE801_3002);
        applyStimulus(1, 1, 0, 0);
        checkOutput("redir_next_pc", outPc, 32'h18);

        // Redirect while fetch is disabled and decode is stalled
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h103);
        checkOutput("idle_redir_valid", {31'b0, outValid}, 32'h0);
        checkOutput("idle_redir_imem", imemAddress, 32'h100);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("idle_hold_valid", {31'b0, outValid}, 32'h0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("idle_resume_pc", outPc, 32'h100);

        // Performance counters
        doReset();
        for (int i = 0; i < 9; i++) applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h40);
`ifdef IFU_PERF_CNT_EN
        checkOutput("perf10_fetched", perfFetched, 32'd10);
        checkOutput("perf10_flushed", perfFlushed, 32'd2);
`else
        checkOutput("perf10_fetched", perfFetched, 32'd0);
        checkOutput("perf10_flushed", perfFlushed, 32'd0);
`endif

        // Randomized traffic, with occasional mid-stream resets
        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset();
            applyStimulus(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
                          $urandom());
        end

        // Wrap-around of the PC and reset during streaming
        @(negedge clk);
        wResetN = 1'b1;
        @(negedge clk);
        wFetchEn = 1'b1;
        wReady   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("wrap_pc0", wPc, 32'hFFFF_FFFC);
        checkOutput("wrap_imem0", wImemAddress, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("wrap_pc1", wPc, 32'h0);
        checkOutput("wrap_instr1", wInstr, 32'hEF20_000C);
        @(negedge clk);
        wResetN = 1'b0;
        #1;
        checkOutput("wrap_rst_valid", {31'b0, wValid}, 32'h0);
        checkOutput("wrap_rst_imem", wImemAddress, 32'hFFFF_FFFC);
        @(negedge clk);
        wResetN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("wrap_restart_pc", wPc, 32'hFFFF_FFFC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
